// File: rtl/clock_reset_ctrl.sv
// Clock and reset controller: qualifies an asynchronous PLL lock, releases the
// system reset after a stable lock window, and generates per-channel
// clock-enable pulses from programmable divisors while running.
module clock_reset_ctrl #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int NUM_CE             = 2,
   parameter int DIV_WIDTH          = 8
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          locked,
   input  logic [NUM_CE*DIV_WIDTH-1:0]   div,
   output logic                          sys_resetn,
   output logic [NUM_CE-1:0]             ce,
   output logic [7:0]                    lock_lost_count
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   localparam int CW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_ONE  = CW'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

   state_t          state;
   state_t          next_state;
   logic            lock_s1;
   logic            locked_s;
   logic [CW-1:0]   stable_cnt;
   logic            run_now;

   assign run_now = (state == RUN);

   // Two-flop synchroniser bringing the PLL lock into the clock domain
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lock_s1  <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         lock_s1  <= locked;
         locked_s <= lock_s1;
      end
   end

   // Lock qualification state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= WAIT_LOCK;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode: any lock drop sends the controller back to waiting
   always_comb begin
      next_state = state;
      case (state)
         WAIT_LOCK: begin
            if (locked_s) begin
               next_state = STABLE;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               next_state = WAIT_LOCK;
            end else if (stable_cnt == STABLE_LAST) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               next_state = WAIT_LOCK;
            end
         end
         default: begin
            next_state = WAIT_LOCK;
         end
      endcase
   end

   // Stable-lock counter, cleared outside STABLE and stopping at its terminal value
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stable_cnt <= '0;
      end else if (state == STABLE) begin
         if (locked_s && (stable_cnt != STABLE_LAST)) begin
            stable_cnt <= stable_cnt + STABLE_ONE;
         end
      end else begin
         stable_cnt <= '0;
      end
   end

   // Saturating count of lock losses observed while running
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lock_lost_count <= 8'd0;
      end else if (run_now && !locked_s && (lock_lost_count != 8'hFF)) begin
         lock_lost_count <= lock_lost_count + 8'd1;
      end
   end

   // System reset released on the same edge the controller enters RUN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sys_resetn <= 1'b0;
      end else begin
         sys_resetn <= (next_state == RUN);
      end
   end

   for (genvar i = 0; i < NUM_CE; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] div_i;
      logic [DIV_WIDTH-1:0] period_new;
      logic [DIV_WIDTH-1:0] period;
      logic [DIV_WIDTH-1:0] count;

      assign div_i      = div[i*DIV_WIDTH +: DIV_WIDTH];
      assign period_new = (div_i == '0) ? DIV_ONE : div_i;
      assign ce[i]      = run_now && (count == (period - DIV_ONE));

      // Period counter; the divisor is only picked up at a period boundary
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            count  <= '0;
            period <= DIV_ONE;
         end else if (!run_now || ce[i]) begin
            count  <= '0;
            period <= period_new;
         end else begin
            count  <= count + DIV_ONE;
         end
      end
   end

endmodule

// File: tb/tb_clock_reset_ctrl.sv
// Self-checking bench for clock_reset_ctrl with a lock-streak/countdown model.
module tb_clock_reset_ctrl;

   localparam int L  = 16;
   localparam int NC = 2;
   localparam int DW = 4;

   logic             clock;
   logic             resetn;
   logic             locked;
   logic [NC*DW-1:0] div;
   logic             sys_resetn;
   logic [NC-1:0]    ce;
   logic [7:0]       lock_lost_count;

   int tests;
   int failures;

   int m_s1, m_s2, streak, lost;
   int d [NC];
   logic [10:0] exp_vec;
   logic [10:0] obs;

   clock_reset_ctrl #(
      .LOCK_STABLE_CYCLES(L),
      .NUM_CE(NC),
      .DIV_WIDTH(DW)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .locked(locked),
      .div(div),
      .sys_resetn(sys_resetn),
      .ce(ce),
      .lock_lost_count(lock_lost_count)
   );

   // Free-running clock
   always #5 clock = ~clock;

   function automatic int per_of(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic build_expect();
      logic [NC-1:0] e_ce;
      for (int i = 0; i < NC; i++) begin
         e_ce[i] = (streak > L) && (d[i] == 1);
      end
      exp_vec = {(streak > L), e_ce, 8'(lost)};
      obs     = {sys_resetn, ce, lock_lost_count};
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; streak = 0; lost = 0;
      for (int i = 0; i < NC; i++) d[i] = 0;
      build_expect();
   endtask

   // One clock: advance the model with the inputs seen at the edge, sample 1ns later
   task automatic tick();
      int  ls;
      bit  was_run, now_run;
      @(posedge clock);
      if (!resetn) begin
         model_reset();
      end else begin
         ls = m_s2; m_s2 = m_s1; m_s1 = int'(locked);
         was_run = (streak > L);
         if (ls != 0) begin
            if (streak <= L) streak++;
         end else begin
            if (was_run && lost < 255) lost++;
            streak = 0;
         end
         now_run = (streak > L);
         for (int i = 0; i < NC; i++) begin
            if (!now_run) d[i] = 0;
            else if (!was_run || d[i] == 1) d[i] = per_of(int'(div[i*DW +: DW]));
            else d[i] = d[i] - 1;
         end
      end
      #1;
      build_expect();
   endtask

   task automatic reset_dut();
      resetn = 0;
      locked = 0;
      tick();
      tick();
      resetn = 1;
      model_reset();
   endtask

   task automatic test_reset();
      resetn = 0;
      locked = 1;
      div = 8'h31;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL reset cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
      locked = 0;
      resetn = 1;
      model_reset();
   endtask

   task automatic test_release_latency();
      int n;
      reset_dut();
      div = {4'd3, 4'd1};
      locked = 1;
      n = 0;
      do begin
         tick();
         n++;
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL latency cyc %0d: got %b expected %b", n, obs, exp_vec);
         end
      end while (sys_resetn !== 1'b1 && n < 40);
      tests++;
      if (n !== 19) begin
         failures++;
         $display("[TB] FAIL latency edges: got %0d expected 19", n);
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL ce_pattern cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
   endtask

   task automatic test_glitch();
      int n;
      reset_dut();
      div = {4'd2, 4'd5};
      locked = 1;
      n = 0;
      while (streak != 11 && n < 40) begin
         tick();
         n++;
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL glitch_pre cyc %0d: got %b expected %b", n, obs, exp_vec);
         end
      end
      locked = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL glitch_low cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
      locked = 1;
      n = 0;
      do begin
         tick();
         n++;
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL glitch_requal cyc %0d: got %b expected %b", n, obs, exp_vec);
         end
      end while (sys_resetn !== 1'b1 && n < 40);
      tests++;
      if (n !== 19 || lock_lost_count !== 8'd0) begin
         failures++;
         $display("[TB] FAIL glitch_restart: got edges %0d count %0d expected 19 and 0", n, lock_lost_count);
      end
   endtask

   task automatic test_lock_loss();
      locked = 0;
      tick();
      locked = 1;
      for (int c = 0; c < 24; c++) begin
         tick();
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL lock_loss cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
      tests++;
      if (lock_lost_count !== 8'd1 || sys_resetn !== 1'b1) begin
         failures++;
         $display("[TB] FAIL lock_loss_final: got count %0d sysr %b expected 1 and 1", lock_lost_count, sys_resetn);
      end
   endtask

   task automatic test_saturation();
      reset_dut();
      div = {4'd3, 4'd2};
      for (int k = 0; k < 300; k++) begin
         locked = 1;
         for (int c = 0; c < 22; c++) begin
            tick();
            tests++;
            if (obs !== exp_vec) begin
               failures++;
               $display("[TB] FAIL saturation loop %0d cyc %0d: got %b expected %b", k, c, obs, exp_vec);
            end
         end
         locked = 0;
         tick();
      end
      locked = 1;
      for (int c = 0; c < 22; c++) tick();
      tests++;
      if (lock_lost_count !== 8'd255) begin
         failures++;
         $display("[TB] FAIL saturation_final: got %0d expected 255", lock_lost_count);
      end
   endtask

   task automatic test_div_change();
      int n;
      logic [10:0] got_ce0;
      logic [10:0] want_ce0;
      reset_dut();
      div = {4'd3, 4'd4};
      locked = 1;
      n = 0;
      while (!exp_vec[8] && n < 60) begin
         tick();
         n++;
      end
      tests++;
      if (ce[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL div_first_pulse: got ce0 %b after %0d cycles expected 1", ce[0], n);
      end
      got_ce0  = '0;
      want_ce0 = 11'b10101010000;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) div[3:0] = 4'd2;
         got_ce0[c] = ce[0];
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL div_change cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
      tests++;
      if (got_ce0 !== want_ce0) begin
         failures++;
         $display("[TB] FAIL div_change_pattern: got %b expected %b", got_ce0, want_ce0);
      end
      div[3:0] = 4'd0;
      for (int c = 0; c < 3; c++) tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         tests++;
         if (ce[0] !== 1'b1 || obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL div_zero cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      reset_dut();
      div = {4'd2, 4'd3};
      locked = 1;
      for (int c = 0; c < 22; c++) tick();
      locked = 0;
      tick();
      locked = 1;
      for (int c = 0; c < 22; c++) tick();
      tests++;
      if (obs !== exp_vec || lock_lost_count !== 8'd1) begin
         failures++;
         $display("[TB] FAIL async_pre: got %b expected %b", obs, exp_vec);
      end
      #3;
      resetn = 0;
      model_reset();
      #1;
      obs = {sys_resetn, ce, lock_lost_count};
      tests++;
      if (obs !== 11'd0) begin
         failures++;
         $display("[TB] FAIL async_immediate: got %b expected 0", obs);
      end
      tick();
      tick();
      #2;
      resetn = 1;
      n = 0;
      do begin
         tick();
         n++;
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL async_release cyc %0d: got %b expected %b", n, obs, exp_vec);
         end
      end while (sys_resetn !== 1'b1 && n < 40);
      tests++;
      if (n !== 19) begin
         failures++;
         $display("[TB] FAIL async_release_edges: got %0d expected 19", n);
      end
   endtask

   task automatic test_random();
      reset_dut();
      div = 8'($urandom);
      locked = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) locked = ~locked;
         if ($urandom_range(0, 7) == 0) div = 8'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2;
            resetn = 0;
            model_reset();
            #1;
            obs = {sys_resetn, ce, lock_lost_count};
            tests++;
            if (obs !== 11'd0) begin
               failures++;
               $display("[TB] FAIL random_async cyc %0d: got %b expected 0", c, obs);
            end
            tick();
            resetn = 1;
         end
         tick();
         tests++;
         if (obs !== exp_vec) begin
            failures++;
            $display("[TB] FAIL random cyc %0d: got %b expected %b", c, obs, exp_vec);
         end
      end
   endtask

   // Scenario sequence
   initial begin
      clock    = 0;
      resetn   = 0;
      locked   = 0;
      div      = '0;
      tests    = 0;
      failures = 0;
      model_reset();
      test_reset();
      test_release_latency();
      test_glitch();
      test_lock_loss();
      test_div_change();
      test_async_reset();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
